// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 4:1 select datapath: grants one requester at a time,
// forwards its data with valid/ready and forces rotation after MAX_BURST beats.
module mux_rr_arbiter #(
   parameter int DW        = 4,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    req,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] c,
   input  logic [DW-1:0] d,
   output logic [3:0]    gnt,
   output logic [1:0]    sel,
   output logic [DW-1:0] y,
   output logic          y_valid,
   input  logic          y_ready,
   output logic [3:0]    ack,
   output logic          busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

   state_t     state;
   logic [1:0] last;
   logic [3:0] beat_cnt;
   logic [1:0] winner;
   logic       transfer;

   // Scan downwards so the candidate nearest to last+1 is the one left standing.
   always_comb begin
      winner = last;
      for (int i = 4; i >= 1; i--) begin
         if (req[last + 2'(i)]) begin
            winner = last + 2'(i);
         end
      end
   end

   always_comb begin
      case (sel)
         2'd0:    y = a;
         2'd1:    y = b;
         2'd2:    y = c;
         default: y = d;
      endcase
   end

   // A cycle spent in reset never completes a beat, even mid-burst.
   always_comb begin
      y_valid  = (state == GRANT) && req[sel] && !rst;
      transfer = y_valid && y_ready;
      ack      = transfer ? (4'b0001 << sel) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= 4'b0000;
         sel      <= 2'd0;
         busy     <= 1'b0;
         last     <= 2'd3;
         beat_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req != 4'b0000) begin
                  state    <= GRANT;
                  gnt      <= 4'b0001 << winner;
                  sel      <= winner;
                  last     <= winner;
                  busy     <= 1'b1;
                  beat_cnt <= 4'd0;
               end
            end
            GRANT: begin
               if (!req[sel] || (transfer && beat_cnt == LAST_BEAT)) begin
                  state    <= IDLE;
                  gnt      <= 4'b0000;
                  busy     <= 1'b0;
                  beat_cnt <= 4'd0;
               end else if (transfer) begin
                  beat_cnt <= beat_cnt + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= 4'b0000;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
   a_gnt_busy    : assert property (@(posedge clk) disable iff (rst) ((gnt != 4'b0000) == busy));
   a_ack_subset  : assert property (@(posedge clk) disable iff (rst) ((ack & ~gnt) == 4'b0000));
   a_beat_bound  : assert property (@(posedge clk) disable iff (rst) (32'(beat_cnt) < MAX_BURST));

endmodule
